// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential/branch/jump/return/trap
// address selection, circular return-address stack, alignment and trap capture.
module pc_sequencer #(
  parameter int unsigned          AddrSize    = 32,
  parameter int unsigned          PcIncr      = 4,
  parameter logic [AddrSize-1:0]  ResetVector = '0,
  parameter logic [AddrSize-1:0]  TrapVector  = AddrSize'(32'h0000_0100),
  parameter int unsigned          RasDepth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                latch_i,
  input  logic [1:0]          sel_i,
  input  logic [AddrSize-1:0] offset_i,
  input  logic [AddrSize-1:0] target_i,
  input  logic                push_i,
  input  logic                pop_i,
  output logic [AddrSize-1:0] pc_o,
  output logic [AddrSize-1:0] next_pc_o,
  output logic [AddrSize-1:0] epc_o,
  output logic [1:0]          cause_o,
  output logic                trap_o,
  output logic                ras_empty_o,
  output logic                ras_full_o
);

  localparam int unsigned PtrW = $clog2(RasDepth);
  localparam int unsigned CntW = $clog2(RasDepth + 1);
  localparam logic [AddrSize-1:0] AlignMask = AddrSize'(PcIncr - 1);
  localparam logic [AddrSize-1:0] IncrVal   = AddrSize'(PcIncr);
  localparam logic [CntW-1:0]     CntMax    = CntW'(RasDepth);

  localparam logic [1:0] SelSeq  = 2'b00;
  localparam logic [1:0] SelRel  = 2'b01;
  localparam logic [1:0] SelJump = 2'b10;
  localparam logic [1:0] SelTrap = 2'b11;

  logic [AddrSize-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [1:0]          cause_q, cause_d;
  logic                trap_q, trap_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AddrSize-1:0] ras_q [RasDepth];

  logic [PtrW-1:0]     top_idx;
  logic [AddrSize-1:0] ras_top, pc_inc, cand;
  logic                take_trap, checked;
  logic [1:0]          trap_cause;
  logic                ras_we;
  logic [PtrW-1:0]     ras_widx;

  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CntMax);
  assign top_idx     = ptr_q - PtrW'(1);
  assign ras_top     = ras_q[top_idx];
  assign pc_inc      = pc_q + IncrVal;

  // Address source selection, priority order trap > underflow > pop > rel > jump > seq.
  always_comb begin
    take_trap  = 1'b0;
    trap_cause = 2'b00;
    checked    = 1'b0;
    cand       = pc_inc;
    if (sel_i == SelTrap) begin
      take_trap  = 1'b1;
      trap_cause = 2'b11;
    end else if (pop_i && ras_empty_o) begin
      take_trap  = 1'b1;
      trap_cause = 2'b10;
    end else if (pop_i) begin
      cand    = ras_top;
      checked = 1'b1;
    end else if (sel_i == SelRel) begin
      cand    = pc_q + offset_i;
      checked = 1'b1;
    end else if (sel_i == SelJump) begin
      cand    = {target_i[AddrSize-1:1], 1'b0};
      checked = 1'b1;
    end
    if (checked && ((cand & AlignMask) != '0)) begin
      take_trap  = 1'b1;
      trap_cause = 2'b01;
    end
    next_pc_o = take_trap ? TrapVector : cand;
  end

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    trap_d   = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (latch_i) begin
      pc_d = next_pc_o;
      if (take_trap) begin
        epc_d   = pc_q;
        cause_d = trap_cause;
        trap_d  = 1'b1;
      end else if (push_i && pop_i) begin
        // Co-routine swap: return to top, replace it with our own return address.
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else if (push_i) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PtrW'(1);
        cnt_d  = ras_full_o ? cnt_q : cnt_q + CntW'(1);
      end else if (pop_i) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= ResetVector;
      epc_q   <= '0;
      cause_q <= 2'b00;
      trap_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      trap_q  <= trap_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk_i) begin
    if (ras_we) begin
      ras_q[ras_widx] <= pc_inc;
    end
  end

  assign pc_o    = pc_q;
  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign trap_o  = trap_q;

  logic unused_sel_seq;
  assign unused_sel_seq = ^SelSeq;

endmodule
